// File: rtl/sync_frame_pkg.sv
// Shared definitions for the sync-pattern link: FSM state encodings and the
// default sync word, also used by the detector's bench model.
package sync_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int            SYNC_W    = 6;
  localparam logic [SYNC_W-1:0] SYNC_WORD = 6'b101011;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_frame_tx_if.sv
// Frame request / serial output bundle between a frame source and sync_frame_tx.
interface sync_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              data_out;
  logic              valid;
  logic              busy;
  logic              done;
  logic [1:0]        state;

  modport master (
    output start, data_in,
    input  data_out, valid, busy, done, state
  );

  modport slave (
    input  start, data_in,
    output data_out, valid, busy, done, state
  );
endinterface

// File: rtl/tx_shift_reg.sv
// Load / shift-left register presenting its MSB as the serial bit; clear wins
// over load, load wins over shift.
module tx_shift_reg #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] load_val_i,
  output logic         msb_o
);

  logic [W-1:0] sreg_q, sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (clr_i)        sreg_d = '0;
    else if (load_i)  sreg_d = load_val_i;
    else if (shift_i) sreg_d = {sreg_q[W-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    sreg_q <= sreg_d;
  end

  assign msb_o = sreg_q[W-1];

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync word then latched payload, MSB-first, one bit
// per clock; outputs decode the registered state and shifter.
module sync_frame_tx
  import sync_frame_pkg::*;
#(
  parameter int               PAT_W   = SYNC_W,
  parameter logic [PAT_W-1:0] PATTERN = SYNC_WORD,
  parameter int               DATA_W  = 8
) (
  input  logic          clk,
  input  logic          reset,
  sync_frame_tx_if.slave bus
);

  localparam int CNT_W = $clog2(max_int(PAT_W, DATA_W)) + 1;
  localparam logic [CNT_W-1:0] PAT_LAST = CNT_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(DATA_W - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, shift, msb;

  tx_shift_reg #(.W(PAT_W + DATA_W)) u_shift (
    .clk        (clk),
    .clr_i      (reset),
    .load_i     (load),
    .shift_i    (shift),
    .load_val_i ({PATTERN, bus.data_in}),
    .msb_o      (msb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // start is only looked at in IDLE, so requests during a frame are dropped
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SYNC;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      ST_SYNC: begin
        shift = 1'b1;
        if (cnt_q == PAT_LAST) begin
          state_d = ST_PAYLOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PAYLOAD: begin
        shift = 1'b1;
        if (cnt_q == DAT_LAST) state_d = ST_DONE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.data_out = 1'b0;
    bus.valid    = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.state    = state_q;
    case (state_q)
      ST_SYNC, ST_PAYLOAD: begin
        bus.valid    = 1'b1;
        bus.busy     = 1'b1;
        bus.data_out = msb;
      end
      ST_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
